// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single shared memory port.
// Data requests win by default; a waiting fetch is forced through after STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic        imem_ready,
  output logic [31:0] imem_rdata,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic        dmem_ready,
  output logic [31:0] dmem_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int            CW    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic          r_i_pend;
  logic [31:0]   r_i_addr;
  logic          r_d_pend;
  logic [31:0]   r_d_addr;
  logic [31:0]   r_d_wdata;
  logic [3:0]    r_d_wstrb;
  logic [CW-1:0] r_starve_cnt;

  logic          r_mem_valid;
  logic          r_mem_instr;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic [3:0]    r_mem_wstrb;

  logic          w_i_req;
  logic          w_d_req;
  logic          w_starved;
  logic          w_grant_i;
  logic          w_grant_d;

  // A request arriving this cycle is visible to the grant logic directly, giving 1-cycle issue latency.
  assign w_i_req   = r_i_pend | imem_valid;
  assign w_d_req   = r_d_pend | dmem_valid;
  assign w_starved = (r_starve_cnt == LIMIT);

  always_comb begin
    w_state_next = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    imem_ready   = 1'b0;
    imem_rdata   = 32'h0;
    dmem_ready   = 1'b0;
    dmem_rdata   = 32'h0;
    case (r_state)
      IDLE: begin
        if (w_i_req && (!w_d_req || w_starved)) begin
          w_grant_i    = 1'b1;
          w_state_next = BUSY_I;
        end else if (w_d_req) begin
          w_grant_d    = 1'b1;
          w_state_next = BUSY_D;
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          imem_ready   = 1'b1;
          imem_rdata   = mem_rdata;
          w_state_next = IDLE;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          dmem_ready   = 1'b1;
          dmem_rdata   = mem_rdata;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i_pend     <= 1'b0;
      r_i_addr     <= 32'h0;
      r_d_pend     <= 1'b0;
      r_d_addr     <= 32'h0;
      r_d_wdata    <= 32'h0;
      r_d_wstrb    <= 4'h0;
      r_starve_cnt <= '0;
    end else begin
      // Pending slots always take the newest request; a grant consumes whatever is newest.
      r_i_pend <= w_i_req & ~w_grant_i;
      r_d_pend <= w_d_req & ~w_grant_d;
      if (imem_valid) begin
        r_i_addr <= imem_addr;
      end
      if (dmem_valid) begin
        r_d_addr  <= dmem_addr;
        r_d_wdata <= dmem_wdata;
        r_d_wstrb <= dmem_wstrb;
      end
      if (w_grant_i) begin
        r_starve_cnt <= '0;
      end else if (w_grant_d && w_i_req && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + CW'(1);
      end
    end
  end

  // Transaction fields load only on a grant, so they stay stable for the whole transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_valid <= 1'b0;
      r_mem_instr <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_mem_wstrb <= 4'h0;
    end else begin
      r_mem_valid <= w_grant_i | w_grant_d;
      if (w_grant_i) begin
        r_mem_instr <= 1'b1;
        r_mem_addr  <= imem_valid ? imem_addr : r_i_addr;
        r_mem_wdata <= 32'h0;
        r_mem_wstrb <= 4'h0;
      end else if (w_grant_d) begin
        r_mem_instr <= 1'b0;
        r_mem_addr  <= dmem_valid ? dmem_addr  : r_d_addr;
        r_mem_wdata <= dmem_valid ? dmem_wdata : r_d_wdata;
        r_mem_wstrb <= dmem_valid ? dmem_wstrb : r_d_wstrb;
      end
    end
  end

  assign mem_valid = r_mem_valid;
  assign mem_instr = r_mem_instr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-cycle vector table plus scoreboarded multi-cycle sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_addr = 32'h0;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_valid = 1'b0;
  logic [31:0] dmem_addr = 32'h0;
  logic [31:0] dmem_wdata = 32'h0;
  logic [3:0]  dmem_wstrb = 4'h0;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int n_checks = 0;
  int n_errs   = 0;
  bit sb_on    = 1'b0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .imem_valid(imem_valid), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } iss_t;

  iss_t sb_q[$];
  iss_t exp_iss;
  iss_t got_iss;
  int   n_issue = 0;

  typedef struct {
    logic        iv;  logic [31:0] ia;
    logic        dv;  logic [31:0] da; logic [31:0] dw; logic [3:0] ds;
    logic        mr;  logic [31:0] mrd;
    logic        ev;  logic ei; logic [31:0] ea; logic [31:0] ew; logic [3:0] es;
    logic        eir; logic [31:0] eird;
    logic        edr; logic [31:0] edrd;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Issue monitor: every mem_valid pulse is matched against the next expected transaction.
  always @(negedge clk) begin
    if (sb_on && rst && mem_valid) begin
      got_iss = '{instr: mem_instr, addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb};
      n_issue++;
      $display("issue %0d: instr=%0b addr=%h wdata=%h wstrb=%h", n_issue, mem_instr, mem_addr, mem_wdata, mem_wstrb);
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errs++;
        $display("FAIL unexpected_issue: got %h required none", got_iss);
      end else begin
        exp_iss = sb_q.pop_front();
        if (got_iss !== exp_iss) begin
          n_errs++;
          $display("FAIL issue_%0d: got %h required %h", n_issue, got_iss, exp_iss);
        end
      end
    end
  end

  task automatic wait_issue(input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (mem_valid) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_errs++;
      $display("FAIL %s_timeout: mem_valid=0 for 20 cycles, required 1", tag);
    end
  endtask

  // Drives mem_ready for one cycle (optionally with a same-cycle dmem pulse) and checks the ready routing.
  task automatic complete(input bit is_i, input logic [31:0] rd, input bit dv, input logic [31:0] da);
    @(posedge clk); #1;
    mem_ready  = 1'b1;
    mem_rdata  = rd;
    dmem_valid = dv;
    dmem_addr  = da;
    dmem_wdata = 32'h0;
    dmem_wstrb = 4'h0;
    @(negedge clk);
    chk("complete_ready", {imem_ready, imem_rdata, dmem_ready, dmem_rdata},
        is_i ? {1'b1, rd, 1'b0, 32'h0} : {1'b0, 32'h0, 1'b1, rd});
    @(posedge clk); #1;
    mem_ready  = 1'b0;
    mem_rdata  = 32'h0;
    dmem_valid = 1'b0;
  endtask

  initial begin
    //           iv ia        dv da        dw            ds    mr mrd           ev ei ea        ew            es    eir eird          edr edrd
    vecs[0]  = '{1, 32'h100, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 32'h0};
    vecs[1]  = '{0, 32'h0,   0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        1, 1, 32'h100, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0};
    vecs[2]  = '{0, 32'h0,   0, 32'h0,   32'h0,        4'h0, 1, 32'hDEADBEEF, 0, 0, 32'h0,   32'h0,        4'h0, 1, 32'hDEADBEEF, 0, 32'h0};
    vecs[3]  = '{0, 32'h0,   0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 32'h0};
    vecs[4]  = '{0, 32'h0,   0, 32'h0,   32'h0,        4'h0, 1, 32'h12345678, 0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 32'h0};
    vecs[5]  = '{0, 32'h0,   0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 32'h0};
    vecs[6]  = '{1, 32'h400, 1, 32'h200, 32'hCAFEF00D, 4'hF, 0, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 32'h0};
    vecs[7]  = '{0, 32'h0,   0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        1, 0, 32'h200, 32'hCAFEF00D, 4'hF, 0, 32'h0,        0, 32'h0};
    vecs[8]  = '{0, 32'h0,   0, 32'h0,   32'h0,        4'h0, 1, 32'h55AA55AA, 0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        1, 32'h55AA55AA};
    vecs[9]  = '{0, 32'h0,   0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 32'h0};
    vecs[10] = '{0, 32'h0,   0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        1, 1, 32'h400, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0};
    vecs[11] = '{0, 32'h0,   0, 32'h0,   32'h0,        4'h0, 1, 32'h11112222, 0, 0, 32'h0,   32'h0,        4'h0, 1, 32'h11112222, 0, 32'h0};
    vecs[12] = '{0, 32'h0,   0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 32'h0};

    // Reset state
    #13;
    chk("reset_outputs", {mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
                          imem_ready, imem_rdata, dmem_ready, dmem_rdata}, 160'h0);
    #4 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Per-cycle vectors: single fetch, spurious ready in IDLE, simultaneous data/fetch
    for (int i = 0; i < 13; i++) begin
      imem_valid = vecs[i].iv;  imem_addr  = vecs[i].ia;
      dmem_valid = vecs[i].dv;  dmem_addr  = vecs[i].da;
      dmem_wdata = vecs[i].dw;  dmem_wstrb = vecs[i].ds;
      mem_ready  = vecs[i].mr;  mem_rdata  = vecs[i].mrd;
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i), {mem_valid, imem_ready, imem_rdata, dmem_ready, dmem_rdata},
          {vecs[i].ev, vecs[i].eir, vecs[i].eird, vecs[i].edr, vecs[i].edrd});
      if (vecs[i].ev)
        chk($sformatf("vec%0d_fields", i), {mem_instr, mem_addr, mem_wdata, mem_wstrb},
            {vecs[i].ei, vecs[i].ea, vecs[i].ew, vecs[i].es});
      @(posedge clk); #1;
    end
    imem_valid = 1'b0; dmem_valid = 1'b0; mem_ready = 1'b0;

    // Starvation: fetch waits behind four data grants, then beats the fifth
    sb_on = 1'b1;
    sb_q.push_back('{1'b0, 32'h1000, 32'h0, 4'h0});
    sb_q.push_back('{1'b0, 32'h1004, 32'h0, 4'h0});
    sb_q.push_back('{1'b0, 32'h1008, 32'h0, 4'h0});
    sb_q.push_back('{1'b0, 32'h100C, 32'h0, 4'h0});
    sb_q.push_back('{1'b1, 32'h2000, 32'h0, 4'h0});
    sb_q.push_back('{1'b0, 32'h1010, 32'h0, 4'h0});
    imem_valid = 1'b1; imem_addr = 32'h2000;
    dmem_valid = 1'b1; dmem_addr = 32'h1000; dmem_wdata = 32'h0; dmem_wstrb = 4'h0;
    @(posedge clk); #1;
    imem_valid = 1'b0; dmem_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_issue("starve_data");
      complete(1'b0, 32'hA000 + 32'(k), 1'b1, 32'h1004 + 32'(4 * k));
    end
    wait_issue("starve_fetch");
    complete(1'b1, 32'hF00DF00D, 1'b0, 32'h0);
    wait_issue("starve_last");
    complete(1'b0, 32'hB0B0B0B0, 1'b0, 32'h0);

    // Overwrite of a pending data request while a fetch is in flight
    sb_q.push_back('{1'b1, 32'h3000, 32'h0, 4'h0});
    sb_q.push_back('{1'b0, 32'h304,  32'h0, 4'h0});
    sb_q.push_back('{1'b1, 32'h3100, 32'h0, 4'h0});
    imem_valid = 1'b1; imem_addr = 32'h3000;
    @(posedge clk); #1;
    imem_valid = 1'b0;
    wait_issue("ovw_fetch");
    @(posedge clk); #1;
    dmem_valid = 1'b1; dmem_addr = 32'h300;
    imem_valid = 1'b1; imem_addr = 32'h3100;
    @(posedge clk); #1;
    dmem_addr = 32'h304;
    imem_valid = 1'b0;
    @(negedge clk);
    chk("inflight_hold", {mem_instr, mem_addr}, {1'b1, 32'h3000});
    complete(1'b1, 32'h33333333, 1'b0, 32'h0);
    wait_issue("ovw_data");
    complete(1'b0, 32'h44444444, 1'b0, 32'h0);
    wait_issue("ovw_fetch2");
    complete(1'b1, 32'h55555555, 1'b0, 32'h0);

    // Reset while a store is in flight
    sb_q.push_back('{1'b0, 32'h500, 32'hA5, 4'h3});
    dmem_valid = 1'b1; dmem_addr = 32'h500; dmem_wdata = 32'hA5; dmem_wstrb = 4'h3;
    @(posedge clk); #1;
    dmem_valid = 1'b0;
    wait_issue("rst_data");
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_outputs", {mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
                            imem_ready, imem_rdata, dmem_ready, dmem_rdata}, 160'h0);
    @(posedge clk); #1;
    mem_ready = 1'b1; mem_rdata = 32'h77;
    @(negedge clk);
    chk("rst_no_ready", {imem_ready, imem_rdata, dmem_ready, dmem_rdata}, 160'h0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst_after_idle%0d", k), {mem_valid, imem_ready, dmem_ready}, 160'h0);
    end

    chk("sb_drained", 160'(sb_q.size()), 160'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning max consecutive data grants while an instruction request waits.
REQ-002 SHALL have port clk  in  1  single clock, rising-edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port imem_valid  in  1  one-cycle fetch request pulse.
REQ-005 SHALL have port imem_addr  in  32  fetch address.
REQ-006 SHALL have port imem_ready  out  1  fetch completion pulse.
REQ-007 SHALL have port imem_rdata  out  32  fetch data, valid with imem_ready.
REQ-008 SHALL have port dmem_valid  in  1  one-cycle load/store request pulse.
REQ-009 SHALL have port dmem_addr  in  32  data address.
REQ-010 SHALL have port dmem_wdata  in  32  store data.
REQ-011 SHALL have port dmem_wstrb  in  4  byte strobes; 0 = load.
REQ-012 SHALL have port dmem_ready  out  1  data completion pulse.
REQ-013 SHALL have port dmem_rdata  out  32  load data, valid with dmem_ready.
REQ-014 SHALL have port mem_valid  out  1  one-cycle issue pulse to shared memory.
REQ-015 SHALL have port mem_instr  out  1  1 = fetch transaction.
REQ-016 SHALL have ports mem_addr, mem_wdata  out  32 each, and mem_wstrb  out  4: transaction fields.
REQ-017 SHALL have ports mem_ready  in  1 and mem_rdata  in  32: memory completion and read data.

Function
REQ-018 SHALL capture each requester's fields into its own pending register on the cycle its valid is high.
REQ-019 SHALL implement states IDLE, BUSY_I, BUSY_D.
REQ-020 In IDLE with any pending request, SHALL grant one request, pulse mem_valid for exactly one cycle on the next edge, clear that pending flag, and enter BUSY_I or BUSY_D.
REQ-021 SHALL give data priority when both are pending, unless starve_cnt equals STARVE_LIMIT; then fetch SHALL win.
REQ-022 starve_cnt SHALL increment on each data grant made while a fetch is pending, saturate at STARVE_LIMIT, and clear on any fetch grant.
REQ-023 mem_addr, mem_wdata, mem_wstrb and mem_instr SHALL be registered and held stable from the issue cycle until mem_ready; fetch SHALL drive mem_wstrb=0 and mem_wdata=0.
REQ-024 In BUSY_x, SHALL pass mem_ready combinationally to the granted requester's ready, with mem_rdata on its rdata, and return to IDLE on that edge.
REQ-025 Ungranted ready SHALL be 0; both rdata outputs SHALL be 0 when their ready is 0.
REQ-026 Minimum latency from request pulse to mem_valid SHALL be 1 cycle; back-to-back issues SHALL be separated by at least 1 IDLE cycle.
REQ-027 A new valid from a requester whose request is pending but not issued SHALL overwrite the pending fields.
REQ-028 A new valid from the requester whose transaction is in flight SHALL be captured as pending and SHALL NOT disturb the in-flight fields.
REQ-029 mem_ready in IDLE SHALL be ignored, with no ready pulse generated.
REQ-030 A request pulse in the same cycle as mem_ready SHALL be captured and SHALL be eligible for grant in the following IDLE cycle.

Reset
REQ-031 On rst=0, SHALL immediately force IDLE, clear pending flags and starve_cnt, and drive all outputs to 0, including mid-transaction; an in-flight transaction SHALL be dropped with no ready pulse.

Verification
REQ-032 Single fetch: imem_valid, addr 0x100 -> mem_valid 1 cycle later with mem_instr=1 and mem_addr=0x100; mem_ready with rdata 0xDEADBEEF -> imem_ready=1 and imem_rdata=0xDEADBEEF in the same cycle.
REQ-033 Simultaneous imem_valid and dmem_valid (store 0x200, wstrb 0xF) -> data issued first, fetch issued after dmem_ready plus 1 IDLE cycle.
REQ-034 Starvation: fetch held pending while 5 data requests arrive, STARVE_LIMIT=4 -> fetch granted after the 4th data completion, before the 5th data request.
REQ-035 Overwrite: two dmem_valid pulses (0x300, then 0x304) while a fetch is in flight -> only 0x304 is issued.
REQ-036 Reset mid-transaction: rst=0 during BUSY_D -> all outputs 0 immediately; a later mem_ready produces no dmem_ready.
REQ-037 Spurious mem_ready in IDLE -> imem_ready=0 and dmem_ready=0, state unchanged.
